// File: rtl/operand_loader_pkg.sv
// Shared definitions for the operand capture stage: operand width and sequencer states.
// The state encoding is 3 bits wide, so three encodings are unused and must recover to S_A.
package operand_loader_pkg;

    localparam int OPERAND_W = 8;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_C    = 3'd2,
        S_D    = 3'd3,
        S_FULL = 3'd4
    } state_t;

endpackage

// File: rtl/operand_loader_edge_sync.sv
// Two-flop synchronizer plus rising-edge detect; pulse is one cycle wide, 2 edges after the input rise.
// Flops reset to RST_VAL so a level already high at reset release can be kept from firing.
module operand_loader_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= RST_VAL;
            sync_2 <= RST_VAL;
            sync_3 <= RST_VAL;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    // sync_3 is only the edge-detect delay, not a third metastability stage
    assign pulse = sync_2 & ~sync_3;

endmodule

// File: rtl/operand_loader.sv
// Loads A, B, C, D in order from a raw write strobe; raises valid when all four are held.
// Registers update 3 edges after the strobe rise; valid is held until ack, writes while full set ovr.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int W = OPERAND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_stb,
    input  logic [W-1:0] data,
    input  logic         clr,
    input  logic         ack,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [1:0]   slot,
    output logic         valid,
    output logic         ovr
);

    state_t state;
    logic   wr_pulse;

    operand_loader_edge_sync #(
        .RST_VAL(1'b1)
    ) u_wr_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (wr_stb),
        .pulse(wr_pulse)
    );

    // slot is assigned alongside every state change so it always equals the decode of state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a     <= '0;
            b     <= '0;
            c     <= '0;
            d     <= '0;
            slot  <= 2'd0;
            valid <= 1'b0;
            ovr   <= 1'b0;
            state <= S_A;
        end else if (clr) begin
            a     <= '0;
            b     <= '0;
            c     <= '0;
            d     <= '0;
            slot  <= 2'd0;
            valid <= 1'b0;
            ovr   <= 1'b0;
            state <= S_A;
        end else begin
            case (state)
                S_A: if (wr_pulse) begin
                    a     <= data;
                    state <= S_B;
                    slot  <= 2'd1;
                end
                S_B: if (wr_pulse) begin
                    b     <= data;
                    state <= S_C;
                    slot  <= 2'd2;
                end
                S_C: if (wr_pulse) begin
                    c     <= data;
                    state <= S_D;
                    slot  <= 2'd3;
                end
                S_D: if (wr_pulse) begin
                    d     <= data;
                    state <= S_FULL;
                    slot  <= 2'd0;
                    valid <= 1'b1;
                end
                S_FULL: begin
                    if (ack) begin
                        // operands are kept on release; a same-cycle write starts the next set at A
                        valid <= 1'b0;
                        if (wr_pulse) begin
                            a     <= data;
                            state <= S_B;
                            slot  <= 2'd1;
                        end else begin
                            state <= S_A;
                            slot  <= 2'd0;
                        end
                    end else if (wr_pulse) begin
                        ovr <= 1'b1;
                    end
                end
                default: begin
                    state <= S_A;
                    slot  <= 2'd0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench: stimulus queues each expected output snapshot, a monitor pops one per observed change.
module tb_operand_loader;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        logic [1:0] slot;
        logic       valid;
        logic       ovr;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_stb = 1'b0;
    logic [7:0] data = 8'h00;
    logic       clr = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] a, b, c, d;
    logic [1:0] slot;
    logic       valid;
    logic       ovr;

    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    snap_t exp_q[$];

    operand_loader #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_stb(wr_stb),
        .data  (data),
        .clr   (clr),
        .ack   (ack),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .slot  (slot),
        .valid (valid),
        .ovr   (ovr)
    );

    always #5 clk = ~clk;

    function automatic snap_t cur();
        return {a, b, c, d, slot, valid, ovr};
    endfunction

    task automatic chk_snap(input string name, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got a=%h b=%h c=%h d=%h slot=%0d valid=%b ovr=%b, want a=%h b=%h c=%h d=%h slot=%0d valid=%b ovr=%b",
                     name, act.a, act.b, act.c, act.d, act.slot, act.valid, act.ovr,
                     exp.a, exp.b, exp.c, exp.d, exp.slot, exp.valid, exp.ovr);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                        input logic [7:0] ed, input logic [1:0] es, input logic ev, input logic eo);
        exp_q.push_back({ea, eb, ec, ed, es, ev, eo});
    endtask

    // inputs change 2 time units after the rising edge, well clear of sampling
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // one full strobe: rise, write lands on the 3rd edge, then low long enough to re-arm
    task automatic strobe(input logic [7:0] v);
        data   = v;
        wr_stb = 1'b1;
        repeat (4) tick();
        wr_stb = 1'b0;
        repeat (4) tick();
    endtask

    // monitor: every change of the output set must match the next queued expectation
    initial begin
        snap_t prev;
        snap_t now;
        snap_t e;
        wait (mon_en);
        prev = cur();
        forever begin
            @(negedge clk);
            now = cur();
            if (now !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got a=%h b=%h c=%h d=%h slot=%0d valid=%b ovr=%b, want no change",
                             now.a, now.b, now.c, now.d, now.slot, now.valid, now.ovr);
                end else begin
                    e = exp_q.pop_front();
                    chk_snap("output_update", now, e);
                end
                prev = now;
            end
        end
    end

    initial begin
        // strobe already high while reset is asserted and released
        wr_stb = 1'b1;
        #1 rst = 1'b1;
        #1 chk_snap("reset_state", cur(), '0);
        mon_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (10) tick();
        chk_bit("held_through_reset_no_valid", valid, 1'b0);
        wr_stb = 1'b0;
        repeat (4) tick();

        // held strobe for 50 cycles gives exactly one write
        push(8'hAA, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0);
        data   = 8'hAA;
        wr_stb = 1'b1;
        repeat (50) tick();
        wr_stb = 1'b0;
        repeat (4) tick();

        // async reset mid-cycle clears immediately, before the next edge
        push(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_snap("async_reset_immediate", cur(), '0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // full load sequence
        push(8'h12, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0);
        strobe(8'h12);
        push(8'h12, 8'h34, 8'h00, 8'h00, 2'd2, 1'b0, 1'b0);
        strobe(8'h34);
        push(8'h12, 8'h34, 8'h56, 8'h00, 2'd3, 1'b0, 1'b0);
        strobe(8'h56);
        push(8'h12, 8'h34, 8'h56, 8'h78, 2'd0, 1'b1, 1'b0);
        data   = 8'h78;
        wr_stb = 1'b1;
        repeat (2) tick();
        chk_bit("valid_not_before_3rd_edge", valid, 1'b0);
        tick();
        chk_bit("valid_at_3rd_edge", valid, 1'b1);
        tick();
        wr_stb = 1'b0;
        repeat (4) tick();

        // write while full without ack: discarded, ovr set
        push(8'h12, 8'h34, 8'h56, 8'h78, 2'd0, 1'b1, 1'b1);
        strobe(8'hFF);
        push(8'h12, 8'h34, 8'h56, 8'h78, 2'd0, 1'b0, 1'b1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (3) tick();

        // ack outside full is ignored; refill
        ack = 1'b1;
        repeat (2) tick();
        ack = 1'b0;
        push(8'h01, 8'h34, 8'h56, 8'h78, 2'd1, 1'b0, 1'b1);
        strobe(8'h01);
        push(8'h01, 8'h02, 8'h56, 8'h78, 2'd2, 1'b0, 1'b1);
        strobe(8'h02);
        push(8'h01, 8'h02, 8'h03, 8'h78, 2'd3, 1'b0, 1'b1);
        strobe(8'h03);
        push(8'h01, 8'h02, 8'h03, 8'h04, 2'd0, 1'b1, 1'b1);
        strobe(8'h04);

        // ack coincident with the write pulse: release and load A in one edge
        push(8'h9C, 8'h02, 8'h03, 8'h04, 2'd1, 1'b0, 1'b1);
        data   = 8'h9C;
        wr_stb = 1'b1;
        repeat (2) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        wr_stb = 1'b0;
        repeat (4) tick();

        // clear with a coincident write pulse: everything zero, write dropped
        push(8'h9C, 8'h11, 8'h03, 8'h04, 2'd2, 1'b0, 1'b1);
        strobe(8'h11);
        push(8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0);
        data   = 8'h33;
        wr_stb = 1'b1;
        repeat (2) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        wr_stb = 1'b0;
        repeat (4) tick();

        // next write after clear goes to A
        push(8'h5A, 8'h00, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0);
        strobe(8'h5A);

        repeat (10) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_expectations: got %0d still queued, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
